// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the ALU command sequencer
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_RSVD = 2'b10;
    localparam logic [1:0] ALU_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } alu_state_e;

    function automatic logic is_reserved(input logic [1:0] sel);
        return sel == ALU_RSVD;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command/operand stage driving an external 8-bit adder
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int              WIDTH    = ALU_WIDTH,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,

    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic [1:0]       adder_sel,
    input  logic [WIDTH-1:0] adder_out,
    input  logic             adder_carry,
    input  logic             adder_eq,
    input  logic             adder_gt,
    input  logic             adder_lt,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_eq,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_err,

    output logic [WIDTH-1:0] acc_value
);

    alu_state_e       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       sel_reg;
    logic [WIDTH-1:0] acc;

    // Adder inputs come straight from flops so the external adder settles a full cycle.
    assign adder_a   = a_reg;
    assign adder_b   = b_reg;
    assign adder_sel = sel_reg;
    assign acc_value = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_eq    <= 1'b0;
            res_gt    <= 1'b0;
            res_lt    <= 1'b0;
            res_err   <= 1'b0;
            acc       <= ACC_INIT;
            a_reg     <= '0;
            b_reg     <= '0;
            sel_reg   <= ALU_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        a_reg     <= cmd_use_acc ? acc : cmd_a;
                        b_reg     <= cmd_b;
                        sel_reg   <= cmd_sel;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= adder_out;
                    res_carry <= adder_carry;
                    res_eq    <= adder_eq;
                    res_gt    <= adder_gt;
                    res_lt    <= adder_lt;
                    res_err   <= is_reserved(sel_reg);
                    if (!is_reserved(sel_reg)) begin
                        acc <= adder_out;
                    end
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    // cmd_ready only rises a cycle after the result is taken.
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic [7:0] adder_a;
    logic [7:0] adder_b;
    logic [1:0] adder_sel;
    logic [7:0] adder_out;
    logic       adder_carry;
    logic       adder_eq;
    logic       adder_gt;
    logic       adder_lt;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_eq;
    logic       res_gt;
    logic       res_lt;
    logic       res_err;
    logic [7:0] acc_value;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(8), .ACC_INIT(8'hA5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .adder_a(adder_a), .adder_b(adder_b), .adder_sel(adder_sel),
        .adder_out(adder_out), .adder_carry(adder_carry),
        .adder_eq(adder_eq), .adder_gt(adder_gt), .adder_lt(adder_lt),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt),
        .res_err(res_err), .acc_value(acc_value)
    );

    // Stand-in for the external adder
    logic [8:0] sum9;
    always_comb begin
        sum9 = {1'b0, adder_a} + {1'b0, adder_b};
        case (adder_sel)
            2'b00:   adder_out = sum9[7:0];
            2'b01:   adder_out = adder_a - adder_b;
            2'b11:   adder_out = 8'h00 - adder_b;
            default: adder_out = 8'h00;
        endcase
        adder_carry = sum9[8];
        adder_eq    = adder_a == adder_b;
        adder_gt    = adder_a > adder_b;
        adder_lt    = adder_a < adder_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a command, checks the two-edge latency; leaves bench 1ns after the capture edge.
    task automatic issue(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input logic use_acc);
        cmd_sel     = sel;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("exec_cmd_ready", cmd_ready, 0);
        check("exec_res_valid", res_valid, 0);
        @(posedge clk); #1;
        check("lat_res_valid", res_valid, 1);
    endtask

    task automatic retire();
        @(posedge clk); #1;
        check("retire_res_valid", res_valid, 0);
        check("retire_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int stray;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_sel = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00;
        cmd_use_acc = 1'b0; res_ready = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 8'h00);
        check("rst_flags", {res_carry, res_eq, res_gt, res_lt, res_err}, 5'b0);
        check("rst_acc", acc_value, 8'hA5);
        check("rst_adder_in", {adder_a, adder_b, adder_sel}, 18'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // add with carry out
        issue(2'b00, 8'hF0, 8'h20, 1'b0);
        check("add_data", res_data, 8'h10);
        check("add_flags_cegl", {res_carry, res_eq, res_gt, res_lt}, 4'b1010);
        check("add_err", res_err, 0);
        check("add_acc", acc_value, 8'h10);
        retire();

        // subtract to a negative result
        issue(2'b01, 8'h05, 8'h09, 1'b0);
        check("sub_data", res_data, 8'hFC);
        check("sub_flags_cegl", {res_carry, res_eq, res_gt, res_lt}, 4'b0001);
        retire();

        // two's complement of B
        issue(2'b11, 8'h00, 8'h01, 1'b0);
        check("neg_data", res_data, 8'hFF);
        check("neg_acc", acc_value, 8'hFF);
        retire();

        // accumulator chain; cmd_a is garbage when use_acc is set
        issue(2'b00, 8'h03, 8'h04, 1'b0);
        check("chain1_data", res_data, 8'h07);
        retire();
        issue(2'b00, 8'hEE, 8'h10, 1'b1);
        check("chain2_data", res_data, 8'h17);
        check("chain2_acc", acc_value, 8'h17);
        retire();
        issue(2'b01, 8'hEE, 8'h17, 1'b1);
        check("chain3_data", res_data, 8'h00);
        check("chain3_eq", res_eq, 1);
        check("chain3_carry", res_carry, 0);
        retire();

        // backpressure with a stray command pulse
        res_ready = 1'b0;
        issue(2'b00, 8'h03, 8'h04, 1'b0);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                cmd_sel = 2'b00; cmd_a = 8'h55; cmd_b = 8'h11; cmd_use_acc = 1'b0;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_data !== 8'h07 ||
                res_carry !== 1'b0 || res_lt !== 1'b1)
                stray++;
        end
        cmd_valid = 1'b0;
        check("bp_hold_cycles_bad", stray, 0);
        res_ready = 1'b1;
        retire();
        @(posedge clk); #1;
        check("bp_idle_no_beat", res_valid, 0);
        check("bp_acc_kept", acc_value, 8'h07);

        // reserved select
        issue(2'b10, 8'h12, 8'h34, 1'b0);
        check("rsvd_data", res_data, 8'h00);
        check("rsvd_err", res_err, 1);
        check("rsvd_acc", acc_value, 8'h07);
        retire();
        issue(2'b00, 8'h01, 8'h01, 1'b0);
        check("post_rsvd_err", res_err, 0);
        check("post_rsvd_data", res_data, 8'h02);
        retire();

        // async reset while in EXEC
        cmd_sel = 2'b00; cmd_a = 8'h40; cmd_b = 8'h40; cmd_use_acc = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid_exec_cmd_ready", cmd_ready, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_acc", acc_value, 8'hA5);
        check("mid_rst_adder_sel", adder_sel, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0) stray++;
        end
        check("mid_rst_no_beat", stray, 0);
        check("mid_rst_acc_after", acc_value, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream command/operand stage for the 8-bit adder datapath.
- Accepts ALU commands over a valid/ready handshake and registers the operands.
- Drives the combinational adder's A, B and Adder_Sel inputs, then captures the adder result and its flags into an output register with a valid/ready handshake.
- Keeps an accumulator holding the last result, so commands can chain (A operand = previous result).

Parameters:
- WIDTH, 8, operand/result width; must equal the adder width (8).
- ACC_INIT, 8'h00, accumulator value after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_sel  in  2  00 add, 01 sub, 11 2's complement of B, 10 reserved
- cmd_a  in  WIDTH  operand A (ignored when cmd_use_acc=1)
- cmd_b  in  WIDTH  operand B
- cmd_use_acc  in  1  1: A operand = accumulator
- adder_a  out  WIDTH  to adder A
- adder_b  out  WIDTH  to adder B
- adder_sel  out  2  to adder Adder_Sel
- adder_out  in  WIDTH  from adder Adder_Out
- adder_carry  in  1  from adder CarryOut
- adder_eq / adder_gt / adder_lt  in  1 each  from adder comparison flags
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  captured result
- res_carry, res_eq, res_gt, res_lt  out  1 each  captured flags
- res_err  out  1  command used reserved sel 2'b10
- acc_value  out  WIDTH  current accumulator

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; cmd_ready=1; res_valid=0.
  - res_data=0; all res flags=0; res_err=0.
  - acc=ACC_INIT.
  - Operand registers = 0 and adder_sel=2'b00.
  - Reset mid-EXEC or mid-HOLD drops the in-flight command and its result.
- States: IDLE, EXEC, HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge N, latch a_reg = (cmd_use_acc ? acc : cmd_a), b_reg=cmd_b, sel_reg=cmd_sel; go to EXEC.
- EXEC (cycle N+1):
  - cmd_ready=0.
  - adder_a/adder_b/adder_sel are driven directly from the registers (stable the whole cycle).
  - At edge N+1, capture adder_out and all flags into the res_* registers.
  - res_err = (sel_reg==2'b10).
  - acc <= adder_out, except when res_err: acc is unchanged.
  - res_valid <= 1; go to HOLD.
- HOLD:
  - res_valid=1; res_* are held stable; cmd_ready=0.
  - On res_valid&res_ready: res_valid <= 0, go to IDLE.
  - No combinational path from res_ready to cmd_ready.
- Latency and throughput:
  - Command accept to res_valid = 2 cycles.
  - Minimum 3 cycles per command with res_ready tied high.
- Flags are forwarded from the adder unmodified for every sel (carry reflects A+B even for sub/2's-complement).
- Reserved sel 2'b10: the adder returns 0. The sequencer still produces a result beat with res_data=0 and res_err=1, and does not update the accumulator.
- Accumulator:
  - Wraps modulo 2^WIDTH (no saturation).
  - cmd_use_acc reads the value as of the accept edge; back-to-back chained commands therefore see the previous result.
- Outputs adder_* are purely registered; no combinational path from cmd_* to adder_*.
- cmd_valid deasserting without handshake has no effect.
- Inputs are sampled only at a handshake.

Decomposition:
- Shared package alu_pkg:
  - sel encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_RSVD=2'b10, ALU_NEG=2'b11.
  - State encoding IDLE/EXEC/HOLD.
  - ALU_WIDTH=8.
- No sub-module required. The adder is instantiated by the parent alongside this block, not inside it.
- Optional wrapper alu_top connects alu_op_sequencer to the adder.

Test Plan:
- Add with carry: sel=00, A=8'hF0, B=8'h20, res_ready=1 → res_valid 2 cycles after accept; res_data=8'h10, res_carry=1, res_gt=1, res_eq=0, res_lt=0; acc_value=8'h10.
- Subtract, negative result: sel=01, A=8'h05, B=8'h09 → res_data=8'hFC, res_lt=1, res_carry=0. 2's complement: sel=11, B=8'h01 → res_data=8'hFF.
- Accumulator chain: add A=8'h03, B=8'h04 → 8'h07; then use_acc=1, sel=00, B=8'h10 → 8'h17; then use_acc=1, sel=01, B=8'h17 → 8'h00, res_eq=1.
- Backpressure: res_ready=0 for 5 cycles after res_valid → res_data/flags stable, cmd_ready=0 throughout, a cmd_valid pulse is ignored; raise res_ready → one beat accepted, IDLE next cycle.
- Reserved op: sel=10, A=8'h12, B=8'h34 with acc=8'h07 → res_data=8'h00, res_err=1, acc_value stays 8'h07.
- Reset mid-operation: assert rst during EXEC → res_valid=0, cmd_ready=1, acc_value=ACC_INIT immediately (async), no result beat after release.
